// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hold/flush/redirect controller for the pc_reg -> if_id -> id_ex
//                pipeline, with a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 4,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_en_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              mc_start_i,
    input  logic [CNT_W-1:0]  mc_cycles_i,
    input  logic              bus_hold_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic [4:0]        ex_wd_addr_i,
    input  logic              ex_reg_wen_i,
    input  logic              ex_is_load_i,
    output logic              pc_hold_o,
    output logic              if_id_hold_o,
    output logic              if_id_flush_o,
    output logic              id_ex_hold_o,
    output logic              id_ex_flush_o,
    output logic              jump_en_o,
    output logic [31:0]       jump_addr_o,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // The jump cycle itself is the first flushed cycle, so FLUSH lasts
    // FLUSH_CYCLES-1 cycles and is skipped entirely when FLUSH_CYCLES==1.
    localparam bit                c_use_flush_st = (FLUSH_CYCLES >= 2);
    localparam logic [CNT_W-1:0]  c_flush_load   =
        (FLUSH_CYCLES >= 2) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam logic [PERF_W-1:0] c_stall_max    = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PERF_W-1:0]  r_stall_cnt;

    logic w_haz;
    logic w_mc_multi;
    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_ex_hold;
    logic w_id_ex_flush;
    logic w_jump;

    assign w_haz = ex_is_load_i & ex_reg_wen_i & (ex_wd_addr_i != 5'd0) &
                   ((ex_wd_addr_i == id_rs1_addr_i) | (ex_wd_addr_i == id_rs2_addr_i));

    assign w_mc_multi = mc_start_i & (mc_cycles_i >= CNT_W'(2));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_hold  = 1'b0;
        w_id_ex_flush = 1'b0;
        w_jump        = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (jump_en_i) begin
                    w_jump        = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (c_use_flush_st) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = c_flush_load;
                    end
                end else if (w_mc_multi) begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_id_ex_hold = 1'b1;
                    w_state_nxt  = ST_MC_BUSY;
                    w_cnt_nxt    = mc_cycles_i - CNT_W'(2);
                end else if (bus_hold_i) begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_id_ex_hold = 1'b1;
                end else if (w_haz) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end

            ST_MC_BUSY: begin
                w_pc_hold    = 1'b1;
                w_if_id_hold = 1'b1;
                w_id_ex_hold = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_FLUSH: begin
                w_if_id_flush = 1'b1;
                if (jump_en_i) begin
                    w_jump        = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_cnt_nxt     = c_flush_load;
                end else if (bus_hold_i) begin
                    // Bus stall freezes the flush window in place.
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_id_ex_hold = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Flush overrides hold on the same register; everything is forced low in reset.
    assign pc_hold_o     = rst_n & w_pc_hold;
    assign if_id_hold_o  = rst_n & w_if_id_hold & ~w_if_id_flush;
    assign if_id_flush_o = rst_n & w_if_id_flush;
    assign id_ex_hold_o  = rst_n & w_id_ex_hold & ~w_id_ex_flush;
    assign id_ex_flush_o = rst_n & w_id_ex_flush;
    assign jump_en_o     = rst_n & w_jump;
    assign jump_addr_o   = (rst_n & w_jump) ? jump_addr_i : 32'h0;
    assign state_o       = r_state;
    assign stall_cnt_o   = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (pc_hold_o && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed-vector bench for pipe_ctrl with a queued scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        mc_start_i;
    logic [3:0]  mc_cycles_i;
    logic        bus_hold_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  ex_wd_addr_i;
    logic        ex_reg_wen_i;
    logic        ex_is_load_i;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_hold_o;
    logic        id_ex_flush_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [1:0]  state_o;
    logic [3:0]  stall_cnt_o;

    pipe_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (4),
        .PERF_W       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .mc_start_i    (mc_start_i),
        .mc_cycles_i   (mc_cycles_i),
        .bus_hold_i    (bus_hold_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .ex_wd_addr_i  (ex_wd_addr_i),
        .ex_reg_wen_i  (ex_reg_wen_i),
        .ex_is_load_i  (ex_is_load_i),
        .pc_hold_o     (pc_hold_o),
        .if_id_hold_o  (if_id_hold_o),
        .if_id_flush_o (if_id_flush_o),
        .id_ex_hold_o  (id_ex_hold_o),
        .id_ex_flush_o (id_ex_flush_o),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, jump_en, addr, state, stall}
    logic [43:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_stall = 4'h0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [43:0] e;
            logic [43:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o,
                  jump_en_o, jump_addr_o, state_o, stall_cnt_o};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    // One clock of stimulus plus its expected response; ld drives a load that writes wd.
    task automatic cyc(input logic rst, input logic jmp, input logic [31:0] ja,
                       input logic mc, input logic [3:0] mcc, input logic bh,
                       input logic ld, input logic [4:0] wd, input logic [4:0] rs2,
                       input logic [2:0] e_hold, input logic [1:0] e_flush,
                       input logic e_je, input logic [1:0] e_st, input string nm);
        logic [43:0] ev;
        @(posedge clk);
        #1;
        rst_n         = rst;
        jump_en_i     = jmp;
        jump_addr_i   = ja;
        mc_start_i    = mc;
        mc_cycles_i   = mcc;
        bus_hold_i    = bh;
        ex_is_load_i  = ld;
        ex_reg_wen_i  = ld;
        ex_wd_addr_i  = wd;
        id_rs1_addr_i = 5'd1;
        id_rs2_addr_i = rs2;
        if (!rst) exp_stall = 4'h0;
        if (rst)
            ev = {e_hold[2], e_hold[1], e_flush[1], e_hold[0], e_flush[0], e_je,
                  (e_je ? ja : 32'h0), e_st, exp_stall};
        else
            ev = '0;
        exp_q.push_back(ev);
        name_q.push_back(nm);
        if (rst && e_hold[2] && exp_stall != 4'hF) exp_stall = exp_stall + 4'h1;
    endtask

    task automatic idle(input logic [2:0] e_hold, input logic [1:0] e_flush,
                        input logic [1:0] e_st, input string nm);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0,
            e_hold, e_flush, 1'b0, e_st, nm);
    endtask

    task automatic do_reset(input string nm);
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 4'd4, 1'b1, 1'b1, 5'd5, 5'd5,
            3'b000, 2'b00, 1'b0, 2'd0, nm);
    endtask

    initial begin
        rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0; mc_start_i = 1'b0;
        mc_cycles_i = 4'd0; bus_hold_i = 1'b0; id_rs1_addr_i = 5'd0;
        id_rs2_addr_i = 5'd0; ex_wd_addr_i = 5'd0; ex_reg_wen_i = 1'b0;
        ex_is_load_i = 1'b0;

        // T1: reset dominates a pending jump
        do_reset("t1_reset_a");
        do_reset("t1_reset_b");

        // T2: jump in RUN, one FLUSH cycle, back to RUN
        cyc(1, 1, 32'h100, 0, 4'd0, 0, 0, 5'd0, 5'd0, 3'b000, 2'b11, 1, 2'd0, "t2_jump");
        idle(3'b000, 2'b10, 2'd2, "t2_flush");
        idle(3'b000, 2'b00, 2'd0, "t2_run");

        // T3: 4-cycle op, jump ignored while busy
        cyc(1, 0, 32'h0, 1, 4'd4, 0, 0, 5'd0, 5'd0, 3'b111, 2'b00, 0, 2'd0, "t3_mc_start");
        idle(3'b111, 2'b00, 2'd1, "t3_busy1");
        cyc(1, 1, 32'h200, 0, 4'd0, 0, 0, 5'd0, 5'd0, 3'b111, 2'b00, 0, 2'd1, "t3_busy_jump");
        idle(3'b111, 2'b00, 2'd1, "t3_busy3");
        idle(3'b000, 2'b00, 2'd0, "t3_done");
        cyc(1, 0, 32'h0, 1, 4'd1, 0, 0, 5'd0, 5'd0, 3'b000, 2'b00, 0, 2'd0, "t3_mc_single");

        // T4: load-use hazards
        cyc(1, 0, 32'h0, 0, 4'd0, 0, 1, 5'd5, 5'd5, 3'b110, 2'b01, 0, 2'd0, "t4_haz_rs2");
        cyc(1, 0, 32'h0, 0, 4'd0, 0, 1, 5'd0, 5'd0, 3'b000, 2'b00, 0, 2'd0, "t4_x0_nohaz");
        cyc(1, 0, 32'h0, 0, 4'd0, 0, 1, 5'd1, 5'd7, 3'b110, 2'b01, 0, 2'd0, "t4_haz_rs1");
        cyc(1, 0, 32'h0, 0, 4'd0, 0, 1, 5'd5, 5'd6, 3'b000, 2'b00, 0, 2'd0, "t4_nomatch");
        cyc(1, 0, 32'h0, 0, 4'd0, 0, 0, 5'd5, 5'd5, 3'b000, 2'b00, 0, 2'd0, "t4_not_load");

        // T5: priority, bus hold freezing FLUSH, re-jump inside FLUSH
        do_reset("t5_reset");
        cyc(1, 1, 32'h300, 1, 4'd4, 1, 1, 5'd5, 5'd5, 3'b000, 2'b11, 1, 2'd0, "t5_prio");
        cyc(1, 0, 32'h0, 0, 4'd0, 1, 0, 5'd0, 5'd0, 3'b101, 2'b10, 0, 2'd2, "t5_fl_bh1");
        cyc(1, 0, 32'h0, 0, 4'd0, 1, 0, 5'd0, 5'd0, 3'b101, 2'b10, 0, 2'd2, "t5_fl_bh2");
        idle(3'b000, 2'b10, 2'd2, "t5_release");
        idle(3'b000, 2'b00, 2'd0, "t5_run");
        cyc(1, 1, 32'h400, 0, 4'd0, 0, 0, 5'd0, 5'd0, 3'b000, 2'b11, 1, 2'd0, "t5_jump_a");
        cyc(1, 1, 32'h500, 0, 4'd0, 0, 0, 5'd0, 5'd0, 3'b000, 2'b11, 1, 2'd2, "t5_rejump");
        idle(3'b000, 2'b10, 2'd2, "t5_reflush");
        idle(3'b000, 2'b00, 2'd0, "t5_run2");

        // T6: stall counter saturation, reset in the middle of MC_BUSY
        do_reset("t6_reset");
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 32'h0, 0, 4'd0, 1, 0, 5'd0, 5'd0, 3'b111, 2'b00, 0, 2'd0, "t6_sat");
        idle(3'b000, 2'b00, 2'd0, "t6_sat_final");
        cyc(1, 0, 32'h0, 1, 4'd4, 0, 0, 5'd0, 5'd0, 3'b111, 2'b00, 0, 2'd0, "t6_mc_start");
        idle(3'b111, 2'b00, 2'd1, "t6_busy");
        do_reset("t6_mid_rst");
        idle(3'b000, 2'b00, 2'd0, "t6_after_rst");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
